// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction-fetch stage of the 5-stage RISC-V core. Issues
//             sequential fetch requests to instruction memory over a
//             valid/ready request channel, accepts in-order responses,
//             buffers up to two fetched words and feeds the IF/ID register
//             read by decode. Honours stall from the hazard unit and
//             redirect/flush from EX.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   1   clock
//    reset           in   1   asynchronous active-low reset
//    stall           in   1   hold IF/ID register contents
//    redirect        in   1   branch taken in EX: flush and restart fetch
//    redirect_pc     in  32   new fetch address, valid with redirect
//    imem_req_valid  out  1   fetch request valid
//    imem_req_ready  in   1   memory accepts request
//    imem_addr       out 32   fetch address (current fetch_pc)
//    imem_rsp_valid  in   1   response valid, in request order, <=1/cycle
//    imem_rsp_data   in  32   fetched instruction word
//    instruction     out 32   IF/ID: instruction to decode
//    PC_ID           out 32   IF/ID: PC of instruction
//    valid_ID        out  1   IF/ID: 1 = real instruction, 0 = bubble
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instruction,
  output logic [31:0] PC_ID,
  output logic        valid_ID
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0] fetch_pc_q,    fetch_pc_d;     // next address to request
  logic [31:0] deliver_pc_q,  deliver_pc_d;   // PC of oldest undelivered word
  logic [1:0]  outstanding_q, outstanding_d;  // accepted, not yet answered
  logic [1:0]  buf_count_q,   buf_count_d;    // words held in the FIFO
  logic [1:0]  discard_cnt_q, discard_cnt_d;  // stale responses still to drop
  logic [31:0] fifo0_q,       fifo0_d;        // FIFO head
  logic [31:0] fifo1_q,       fifo1_d;        // FIFO second entry
  logic [31:0] instr_q,       instr_d;        // IF/ID instruction
  logic [31:0] pc_id_q,       pc_id_d;        // IF/ID PC
  logic        valid_q,       valid_d;        // IF/ID valid

  // --------------------------------------------------------------------------
  // Request channel
  // --------------------------------------------------------------------------
  // Credit rule: a request is only issued while every in-flight word has a
  // guaranteed FIFO slot, so a stalled pipeline can never overflow the FIFO.
  logic [2:0] credits_used;
  logic       credit_ok;
  logic       req_fire;

  assign credits_used   = {1'b0, outstanding_q} + {1'b0, buf_count_q};
  assign credit_ok      = (credits_used < 3'd2);
  assign imem_req_valid = reset & ~redirect & credit_ok;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign imem_addr      = fetch_pc_q;

  // --------------------------------------------------------------------------
  // Response classification
  // --------------------------------------------------------------------------
  logic       rsp_stale;       // answer to a request issued before a redirect
  logic       rsp_keep;        // genuine word for the current fetch stream
  logic [1:0] outstanding_after_rsp;

  assign rsp_stale             = imem_rsp_valid & (discard_cnt_q != 2'd0);
  // A word landing in the redirect cycle belongs to the old path: dropped.
  assign rsp_keep              = imem_rsp_valid & (discard_cnt_q == 2'd0) & ~redirect;
  assign outstanding_after_rsp = outstanding_q - {1'b0, imem_rsp_valid};

  // --------------------------------------------------------------------------
  // Delivery / FIFO control
  // --------------------------------------------------------------------------
  logic       pop;        // FIFO head goes to IF/ID
  logic       bypass;     // incoming word goes straight to IF/ID
  logic       push;       // incoming word is stored
  logic [1:0] push_idx;   // slot written after any same-cycle pop

  assign pop      = ~redirect & ~stall & (buf_count_q != 2'd0);
  assign bypass   = ~redirect & ~stall & (buf_count_q == 2'd0) & rsp_keep;
  assign push     = rsp_keep & ~bypass;
  assign push_idx = buf_count_q - {1'b0, pop};

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    deliver_pc_d  = deliver_pc_q;
    outstanding_d = outstanding_q;
    buf_count_d   = buf_count_q;
    discard_cnt_d = discard_cnt_q;
    fifo0_d       = fifo0_q;
    fifo1_d       = fifo1_q;
    instr_d       = instr_q;
    pc_id_d       = pc_id_q;
    valid_d       = valid_q;

    if (redirect) begin
      // Flush wins over stall and over any same-cycle issue or delivery.
      // Everything still in flight afterwards belongs to the old path.
      fetch_pc_d    = redirect_pc;
      deliver_pc_d  = redirect_pc;
      buf_count_d   = 2'd0;
      outstanding_d = outstanding_after_rsp;
      discard_cnt_d = outstanding_after_rsp;
      instr_d       = NOP;
      valid_d       = 1'b0;
    end else begin
      outstanding_d = outstanding_after_rsp + {1'b0, req_fire};

      if (rsp_stale) begin
        discard_cnt_d = discard_cnt_q - 2'd1;
      end

      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end

      // FIFO: shift on pop, then write the new word behind the survivors.
      if (pop) begin
        fifo0_d = fifo1_q;
      end
      if (push) begin
        if (push_idx == 2'd0) begin
          fifo0_d = imem_rsp_data;
        end else begin
          fifo1_d = imem_rsp_data;
        end
      end
      buf_count_d = buf_count_q - {1'b0, pop} + {1'b0, push};

      // IF/ID register. No PC is stored per entry: the head of the stream
      // always sits at deliver_pc and each delivery advances it by 4.
      if (pop || bypass) begin
        instr_d      = pop ? fifo0_q : imem_rsp_data;
        pc_id_d      = deliver_pc_q;
        valid_d      = 1'b1;
        deliver_pc_d = deliver_pc_q + 32'd4;
      end else if (!stall) begin
        instr_d = NOP;
        valid_d = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      deliver_pc_q  <= RESET_PC;
      outstanding_q <= 2'd0;
      buf_count_q   <= 2'd0;
      discard_cnt_q <= 2'd0;
      fifo0_q       <= 32'd0;
      fifo1_q       <= 32'd0;
      instr_q       <= NOP;
      pc_id_q       <= 32'd0;
      valid_q       <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      deliver_pc_q  <= deliver_pc_d;
      outstanding_q <= outstanding_d;
      buf_count_q   <= buf_count_d;
      discard_cnt_q <= discard_cnt_d;
      fifo0_q       <= fifo0_d;
      fifo1_q       <= fifo1_d;
      instr_q       <= instr_d;
      pc_id_q       <= pc_id_d;
      valid_q       <= valid_d;
    end
  end

  assign instruction = instr_q;
  assign PC_ID       = pc_id_q;
  assign valid_ID    = valid_q;

endmodule
`default_nettype wire
